control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle fetch/decode/execute controller for the 16-bit baseline CPU; it drives the ALU from the other side of its control interface. It fetches instruction words over a ready-handshaked memory port, decodes them into ALU control (op, operand b, immediate mode, flag update), and owns the PC and the PSR that latches the ALU's flag outputs. It also sequences register-file writes, LOAD/STOR, Bcond and Jcond.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write strobe (STOR only), valid with mem_req
- mem_addr  out  16  PC in FETCH; rb_data in MEM
- mem_wdata  out  16  ra_data
- mem_ready  in  1  transaction completes at the edge where mem_req&mem_ready
- mem_rdata  in  16  valid in the mem_ready cycle
- ra_addr / rb_addr  out  4  ir[11:8] / ir[3:0]
- ra_data / rb_data  in  16  register file read data (combinational)
- reg_we  out  1  write ra_addr at the next edge
- wb_sel  out  1  0 = ALU result, 1 = mem_rdata
- alu_op  out  4  ALU opcode
- alu_b  out  16  ALU operand b
- alu_imm_mode  out  1  ALU immediate_mode
- alu_update_flags  out  1  ALU update_flags
- alu_carry_in  out  1  = psr C
- alu_carry, alu_low, alu_flag, alu_zero, alu_negative  in  1 each  ALU flags
- pc  out  16  program counter
- ir  out  16  instruction register
- psr  out  5  {C,L,F,Z,N}
- instr_done  out  1  one-cycle pulse in each instruction's final cycle

## Operation
- States: FETCH, DECODE, EXECUTE, MEM. Outputs decode combinationally from state, ir and psr.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: ir<=mem_rdata, pc<=pc+1 (mod 2^16), go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. LOAD/STOR go to MEM; everything else goes to EXECUTE.
- ALU register form (ir[15:12]=0000): ext=ir[7:4] in {0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR, 1011 CMP, 1101 MOV}. Drives alu_op=ext, alu_b=rb_data, alu_imm_mode=0.
- ALU immediate form: ir[15:12] in the same set, or 1111 LUI. Drives alu_op=ir[15:12], alu_b={8'h00,ir[7:0]}, alu_imm_mode=1.
- 1000 with ext 0100 is LSH: alu_op=0100, alu_b=rb_data, alu_imm_mode=0.
- 1000 with ext 000s is LSHI: alu_op=0100, alu_imm_mode=0, alu_b = s ? 16'hFFFF (right) : 16'h0001 (left).
- EXECUTE, ALU op: reg_we=1 and wb_sel=0, except CMP, which does not write.
- Flag update: alu_update_flags=1 for ADD, SUB, CMP in both forms.
  - ADD/SUB: psr C,F <= alu_carry, alu_flag.
  - CMP: psr L,Z,N <= alu_low, alu_zero, alu_negative.
  - Other psr bits hold.
- 0100 ext 0000 LOAD Rdest,Raddr: MEM state, mem_addr=rb_data, mem_we=0. On mem_ready: reg_we=1, wb_sel=1.
- 0100 ext 0100 STOR Rsrc,Raddr: MEM state, mem_we=1, mem_addr=rb_data, mem_wdata=ra_data. No reg_we.
- 1100 Bcond: if taken, pc <= (pc-1) + sext(ir[7:0]), i.e. offset from the branch's own address, mod 2^16.
- 0100 ext 1100 Jcond: if taken, pc <= rb_data.
- Conditions (cond = ir[11:8]):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L&!Z
  - B HS: L|Z
  - C LT: !N&!Z
  - D GE: N|Z
  - E UC: 1
  - F: never
- Any other encoding is a NOP: passes through EXECUTE with no writes.
- After EXECUTE or a completed MEM, return to FETCH. instr_done=1 in that cycle.
- Outside the cases above, reg_we, alu_update_flags, mem_we and mem_req are 0.

## Timing
- Reset (synchronous, wins over everything): at the edge, state=FETCH, pc=RESET_PC, ir=0, psr=0.
  - While reset is held: mem_req=1, mem_addr=RESET_PC, mem_we=0, reg_we=0, alu_update_flags=0, instr_done=0.
  - mem_ready is ignored; no ir latch.
- Reset mid-MEM: the transaction is abandoned, with no reg_we and no further mem_we after the edge.
- Latency with zero-wait memory: 3 cycles per instruction.
  - ALU/branch: FETCH, DECODE, EXECUTE.
  - LOAD/STOR: FETCH, DECODE, MEM.
  - Each cycle with mem_req=1 and mem_ready=0 adds one cycle.
- mem_addr, mem_we and mem_wdata stay stable while mem_req is high and mem_ready is low.
- psr and pc update at the end of the EXECUTE edge, so the next instruction sees the new flags.
- pc wraps from FFFF to 0000.

## Test plan
- Reset: hold reset 3 cycles with mem_ready=1.
  - Expect mem_addr=0000, mem_req=1, psr=0, ir=0, no reg_we.
  - After release, ir latches mem_rdata at the first edge and pc=0001.
- ADDI 0x5101 with R1=7FFF and ALU attached:
  - EXECUTE: alu_op=0101, alu_b=0001, alu_imm_mode=1, alu_update_flags=1, reg_we=1, ra_addr=1.
  - Next cycle: psr C=0, F=1.
  - instr_done on cycle 3.
- CMP 0x02B3 with R2=R3=5 gives psr Z=1.
  - BEQ 0xC0FE fetched at 0011: pc=000F after EXECUTE.
  - Same branch with Z=0: pc=0012.
- LOAD 0x4403 with R3=0200 and mem_ready low 2 cycles in MEM:
  - mem_req held, mem_addr=0200, mem_we=0.
  - Ready cycle: reg_we=1, wb_sel=1, ra_addr=4.
  - Total 5 cycles.
- STOR 0x4543 with R5=BEEF, R3=0300: MEM shows mem_we=1, mem_addr=0300, mem_wdata=BEEF, no reg_we.
- LSHI 0x8213: alu_b=FFFF, alu_imm_mode=0, alu_op=0100.
- Reset asserted during a LOAD wait: next cycle mem_addr=RESET_PC, mem_we=0, no reg_we.

Source files
------------

// File: rtl/control_unit_if.sv
// Memory port between the control unit and instruction/data memory.
// Ready-handshaked: a transfer completes on the edge where mem_req & mem_ready.
interface control_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit baseline CPU.
// Owns PC, IR and PSR; drives ALU control, register writes and memory.
module control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    control_unit_if.master        bus,
    output logic [3:0]            ra_addr,
    output logic [3:0]            rb_addr,
    input  logic [15:0]           ra_data,
    input  logic [15:0]           rb_data,
    output logic                  reg_we,
    output logic                  wb_sel,
    output logic [3:0]            alu_op,
    output logic [15:0]           alu_b,
    output logic                  alu_imm_mode,
    output logic                  alu_update_flags,
    output logic                  alu_carry_in,
    input  logic                  alu_carry,
    input  logic                  alu_low,
    input  logic                  alu_flag,
    input  logic                  alu_zero,
    input  logic                  alu_negative,
    output logic [15:0]           pc,
    output logic [15:0]           ir,
    output logic [4:0]            psr,
    output logic                  instr_done
);

    typedef enum logic [1:0] {
        FETCH, DECODE, EXECUTE, MEM
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [4:0]  psr_q, psr_d;

    logic [3:0] opc, ext, cond;
    logic       is_r, is_i, is_lsh, is_lshi;
    logic       is_load, is_stor, is_bcond, is_jcond;
    logic       is_addsub, is_cmp, alu_wr, taken;
    logic [15:0] br_tgt;

    function automatic logic alu_code(input logic [3:0] c);
        return c inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    endfunction

    assign opc  = ir_q[15:12];
    assign ext  = ir_q[7:4];
    assign cond = ir_q[11:8];

    assign is_r     = (opc == 4'h0) && alu_code(ext);
    assign is_i     = alu_code(opc) || (opc == 4'hF);
    assign is_lsh   = (opc == 4'h8) && (ext == 4'h4);
    assign is_lshi  = (opc == 4'h8) && (ext[3:1] == 3'b000);
    assign is_load  = (opc == 4'h4) && (ext == 4'h0);
    assign is_stor  = (opc == 4'h4) && (ext == 4'h4);
    assign is_jcond = (opc == 4'h4) && (ext == 4'hC);
    assign is_bcond = (opc == 4'hC);

    assign is_addsub = (is_r && (ext == 4'h5 || ext == 4'h9))
                    || (is_i && (opc == 4'h5 || opc == 4'h9));
    assign is_cmp    = (is_r && ext == 4'hB) || (is_i && opc == 4'hB);
    assign alu_wr    = ((is_r || is_i) && !is_cmp) || is_lsh || is_lshi;

    // Branch offset is relative to the branch itself; pc already advanced.
    assign br_tgt = pc_q - 16'd1 + {{8{ir_q[7]}}, ir_q[7:0]};

    // psr layout {C,L,F,Z,N}
    always_comb begin
        taken = 1'b0;
        case (cond)
            4'h0: taken = psr_q[1];
            4'h1: taken = !psr_q[1];
            4'h2: taken = psr_q[4];
            4'h3: taken = !psr_q[4];
            4'h4: taken = psr_q[3];
            4'h5: taken = !psr_q[3];
            4'h6: taken = psr_q[0];
            4'h7: taken = !psr_q[0];
            4'h8: taken = psr_q[2];
            4'h9: taken = !psr_q[2];
            4'hA: taken = !psr_q[3] && !psr_q[1];
            4'hB: taken = psr_q[3] || psr_q[1];
            4'hC: taken = !psr_q[0] && !psr_q[1];
            4'hD: taken = psr_q[0] || psr_q[1];
            4'hE: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_op       = 4'h0;
        alu_b        = rb_data;
        alu_imm_mode = 1'b0;
        unique case (1'b1)
            is_r: begin
                alu_op = ext;
            end
            is_i: begin
                alu_op       = opc;
                alu_b        = {8'h00, ir_q[7:0]};
                alu_imm_mode = 1'b1;
            end
            is_lsh: begin
                alu_op = 4'h4;
            end
            is_lshi: begin
                alu_op = 4'h4;
                alu_b  = ir_q[4] ? 16'hFFFF : 16'h0001;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        ir_d             = ir_q;
        psr_d            = psr_q;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = pc_q;
        bus.mem_wdata    = ra_data;
        reg_we           = 1'b0;
        wb_sel           = 1'b0;
        alu_update_flags = 1'b0;
        instr_done       = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = (is_load || is_stor) ? MEM : EXECUTE;
            end
            EXECUTE: begin
                instr_done       = 1'b1;
                state_d          = FETCH;
                reg_we           = alu_wr;
                alu_update_flags = is_addsub || is_cmp;
                if (is_addsub) begin
                    psr_d[4] = alu_carry;
                    psr_d[2] = alu_flag;
                end
                if (is_cmp) begin
                    psr_d[3] = alu_low;
                    psr_d[1] = alu_zero;
                    psr_d[0] = alu_negative;
                end
                if (is_bcond && taken) pc_d = br_tgt;
                if (is_jcond && taken) pc_d = rb_data;
            end
            MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = rb_data;
                bus.mem_we   = is_stor;
                wb_sel       = is_load;
                if (bus.mem_ready) begin
                    reg_we     = is_load;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        // Reset overrides so the bus looks like a fetch of RESET_PC.
        if (reset) begin
            bus.mem_req      = 1'b1;
            bus.mem_addr     = RESET_PC;
            bus.mem_we       = 1'b0;
            reg_we           = 1'b0;
            alu_update_flags = 1'b0;
            instr_done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            psr_q   <= 5'b00000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            psr_q   <= psr_d;
        end
    end

    assign ra_addr      = ir_q[11:8];
    assign rb_addr      = ir_q[3:0];
    assign alu_carry_in = psr_q[4];
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign psr          = psr_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the bench plays memory, register file
// and ALU, driving hand-computed values and checking controller outputs.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ra_addr, rb_addr;
    logic [15:0] ra_data, rb_data;
    logic        reg_we, wb_sel;
    logic [3:0]  alu_op;
    logic [15:0] alu_b;
    logic        alu_imm_mode, alu_update_flags, alu_carry_in;
    logic        alu_carry, alu_low, alu_flag, alu_zero, alu_negative;
    logic [15:0] pc, ir;
    logic [4:0]  psr;
    logic        instr_done;

    int total = 0;
    int bad   = 0;

    control_unit_if bus ();

    control_unit #(.RESET_PC(16'h0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .ra_addr          (ra_addr),
        .rb_addr          (rb_addr),
        .ra_data          (ra_data),
        .rb_data          (rb_data),
        .reg_we           (reg_we),
        .wb_sel           (wb_sel),
        .alu_op           (alu_op),
        .alu_b            (alu_b),
        .alu_imm_mode     (alu_imm_mode),
        .alu_update_flags (alu_update_flags),
        .alu_carry_in     (alu_carry_in),
        .alu_carry        (alu_carry),
        .alu_low          (alu_low),
        .alu_flag         (alu_flag),
        .alu_zero         (alu_zero),
        .alu_negative     (alu_negative),
        .pc               (pc),
        .ir               (ir),
        .psr              (psr),
        .instr_done       (instr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Fetch w at addr with zero wait; returns one cycle after DECODE.
    task automatic fetch(input logic [15:0] addr, input logic [15:0] w);
        logic [15:0] nxt;
        nxt = addr + 16'd1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = w;
        #1;
        chk("f_addr", bus.mem_addr, addr);
        chk("f_req", {15'd0, bus.mem_req}, 16'd1);
        tick;
        bus.mem_ready = 1'b0;
        #1;
        chk("f_ir", ir, w);
        chk("f_pc", pc, nxt);
        tick;
    endtask

    initial begin
        reset          = 1'b1;
        ra_data        = 16'h0;
        rb_data        = 16'h0;
        alu_carry      = 1'b0;
        alu_low        = 1'b0;
        alu_flag       = 1'b0;
        alu_zero       = 1'b0;
        alu_negative   = 1'b0;
        bus.mem_ready  = 1'b1;
        bus.mem_rdata  = 16'h5101;

        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_addr", bus.mem_addr, 16'h0000);
            chk("rst_req", {15'd0, bus.mem_req}, 16'd1);
            chk("rst_psr", {11'd0, psr}, 16'h0000);
            chk("rst_ir", ir, 16'h0000);
            chk("rst_we", {15'd0, reg_we}, 16'd0);
        end
        reset = 1'b0;

        // ADDI R1,#1 with R1=7FFF -> C=0, F=1
        fetch(16'h0000, 16'h5101);
        ra_data  = 16'h7FFF;
        alu_flag = 1'b1;
        #1;
        chk("addi_op", {12'd0, alu_op}, 16'h0005);
        chk("addi_b", alu_b, 16'h0001);
        chk("addi_imm", {15'd0, alu_imm_mode}, 16'd1);
        chk("addi_upd", {15'd0, alu_update_flags}, 16'd1);
        chk("addi_we", {15'd0, reg_we}, 16'd1);
        chk("addi_ra", {12'd0, ra_addr}, 16'h0001);
        chk("addi_done", {15'd0, instr_done}, 16'd1);
        tick;
        alu_flag = 1'b0;
        chk("addi_psr", {11'd0, psr}, 16'h0004);

        // CMP R2,R3 equal -> Z=1; carry input must be ignored
        fetch(16'h0001, 16'h02B3);
        ra_data   = 16'h0005;
        rb_data   = 16'h0005;
        alu_zero  = 1'b1;
        alu_carry = 1'b1;
        #1;
        chk("cmp_op", {12'd0, alu_op}, 16'h000B);
        chk("cmp_b", alu_b, 16'h0005);
        chk("cmp_we", {15'd0, reg_we}, 16'd0);
        chk("cmp_upd", {15'd0, alu_update_flags}, 16'd1);
        tick;
        alu_zero  = 1'b0;
        alu_carry = 1'b0;
        chk("cmp_psr", {11'd0, psr}, 16'h0006);

        // JUC to 0011
        fetch(16'h0002, 16'h4EC3);
        rb_data = 16'h0011;
        #1;
        chk("juc_we", {15'd0, reg_we}, 16'd0);
        tick;
        chk("juc_pc", pc, 16'h0011);

        // BEQ -2 taken
        fetch(16'h0011, 16'hC0FE);
        tick;
        chk("beq_t_pc", pc, 16'h000F);

        // CMP unequal -> Z=0
        fetch(16'h000F, 16'h02B3);
        tick;
        chk("cmp2_psr", {11'd0, psr}, 16'h0004);

        // NOP
        fetch(16'h0010, 16'h0000);
        #1;
        chk("nop_we", {15'd0, reg_we}, 16'd0);
        chk("nop_upd", {15'd0, alu_update_flags}, 16'd0);
        chk("nop_done", {15'd0, instr_done}, 16'd1);
        tick;

        // BEQ not taken
        fetch(16'h0011, 16'hC0FE);
        tick;
        chk("beq_nt_pc", pc, 16'h0012);

        // LOAD R4,[R3] with two wait cycles
        fetch(16'h0012, 16'h4403);
        rb_data = 16'h0200;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ld_req", {15'd0, bus.mem_req}, 16'd1);
            chk("ld_addr", bus.mem_addr, 16'h0200);
            chk("ld_mwe", {15'd0, bus.mem_we}, 16'd0);
            chk("ld_wait_we", {15'd0, reg_we}, 16'd0);
            chk("ld_wait_done", {15'd0, instr_done}, 16'd0);
            tick;
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h1234;
        #1;
        chk("ld_we", {15'd0, reg_we}, 16'd1);
        chk("ld_wb", {15'd0, wb_sel}, 16'd1);
        chk("ld_ra", {12'd0, ra_addr}, 16'h0004);
        chk("ld_done", {15'd0, instr_done}, 16'd1);
        tick;
        bus.mem_ready = 1'b0;

        // STOR R5,[R3]
        fetch(16'h0013, 16'h4543);
        ra_data = 16'hBEEF;
        rb_data = 16'h0300;
        bus.mem_ready = 1'b1;
        #1;
        chk("st_mwe", {15'd0, bus.mem_we}, 16'd1);
        chk("st_addr", bus.mem_addr, 16'h0300);
        chk("st_wdata", bus.mem_wdata, 16'hBEEF);
        chk("st_we", {15'd0, reg_we}, 16'd0);
        tick;
        bus.mem_ready = 1'b0;

        // LSHI right
        fetch(16'h0014, 16'h8213);
        #1;
        chk("lshi_b", alu_b, 16'hFFFF);
        chk("lshi_imm", {15'd0, alu_imm_mode}, 16'd0);
        chk("lshi_op", {12'd0, alu_op}, 16'h0004);
        chk("lshi_we", {15'd0, reg_we}, 16'd1);
        tick;

        // Jump to FFFF, then fetch there and wrap to 0000
        fetch(16'h0015, 16'h4EC3);
        rb_data = 16'hFFFF;
        tick;
        chk("jmp_ff_pc", pc, 16'hFFFF);
        fetch(16'hFFFF, 16'h0000);
        tick;

        // LOAD wait interrupted by reset
        fetch(16'h0000, 16'h4403);
        rb_data = 16'h0200;
        #1;
        chk("ldr_addr", bus.mem_addr, 16'h0200);
        reset = 1'b1;
        #1;
        chk("ldr_rst_we", {15'd0, reg_we}, 16'd0);
        tick;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("ldr_addr2", bus.mem_addr, 16'h0000);
        chk("ldr_mwe", {15'd0, bus.mem_we}, 16'd0);
        chk("ldr_we", {15'd0, reg_we}, 16'd0);
        chk("ldr_pc", pc, 16'h0000);
        chk("ldr_psr", {11'd0, psr}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
